stop_key_conditioner: RTL and testbench

- Input-side producer of the Stop events that the stacker game consumes.
- Synchronizes and debounces raw active-low push keys, and accepts presses only in stacking order (highest index first).
- Drives the latched active-low Stop levels plus one-cycle event pulses for the game logic.
- Sits between board keys and the game FSM/counters, replacing direct key-to-Stop wiring.

---
 rtl/stop_key_conditioner.sv | 212 +++++++++++++++++++++
 tb/tb_stop_key_conditioner.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_key_conditioner.sv
// -----------------------------------------------------------------------------
// stop_key_conditioner
//
// Purpose: conditions raw active-low board keys into the Stop events used by
// the stacker game. Each key passes through a two-flop synchronizer and a
// debouncer. Each debounced press (a 1->0 edge of the stable level) is then
// checked against the stacking order, which expects the highest index first.
// Accepted presses latch the matching Stop line low and give a one-cycle
// PressPulse. Out-of-order presses, and presses after the round is done,
// give a one-cycle ErrorPulse.
//
// Build option:
//   STOP_ANY_ORDER_EN - when defined, any key not yet stopped is accepted in
//                       any order. Several keys can be accepted in the same
//                       cycle. Only presses on keys that are already stopped
//                       (or presses in DONE) raise ErrorPulse.
//
// Ports:
//   Clock_i       in   1              system clock
//   Resetn_i      in   1              asynchronous active-low reset
//   KeyIn_i       in   NUM_BTN        raw asynchronous keys, 0 = pressed
//   Clear_i       in   1              synchronous re-arm for a new round
//   StopOut_o     out  NUM_BTN        latched Stop levels, 0 = slot stopped
//   PressPulse_o  out  NUM_BTN        one-cycle pulse per accepted press
//   ErrorPulse_o  out  1              one-cycle pulse on any rejected press
//   Remaining_o   out  clog2(N+1)     slots not yet stopped
//   Done_o        out  1              high once Remaining reaches 0
// -----------------------------------------------------------------------------
module stop_key_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                               Clock_i,
    input  logic                               Resetn_i,
    input  logic [NUM_BTN-1:0]                 KeyIn_i,
    input  logic                               Clear_i,
    output logic [NUM_BTN-1:0]                 StopOut_o,
    output logic [NUM_BTN-1:0]                 PressPulse_o,
    output logic                               ErrorPulse_o,
    output logic [$clog2(NUM_BTN+1)-1:0]       Remaining_o,
    output logic                               Done_o
);

    localparam int                REM_W    = $clog2(NUM_BTN + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REM_W-1:0]  REM_FULL = REM_W'(NUM_BTN);

    localparam logic [0:0] ST_ARMED = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer. Both stages reset to the released level (1).
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;

    always_ff @(posedge Clock_i or negedge Resetn_i) begin
        if (!Resetn_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= KeyIn_i;
            sync2_q <= sync1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Per-key debouncer. The press event is taken from the next-state value,
    // so the FSM reacts on the same edge that the stable level flips. This
    // puts the PressPulse on edge DEBOUNCE_CYCLES+1 after the first low
    // sample.
    // -------------------------------------------------------------------------
    logic [NUM_BTN-1:0] press_evt;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_debounce
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;

            always_comb begin
                cnt_d    = cnt_q;
                stable_d = stable_q;
                if (sync2_q[gi] == stable_q) begin
                    // Agreement (or a bounce back) restarts the hold count.
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    stable_d = sync2_q[gi];
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge Clock_i or negedge Resetn_i) begin
                if (!Resetn_i) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b1;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            // Only a 1->0 edge is an event. Releases are silent.
            assign press_evt[gi] = stable_q & ~stable_d;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Order FSM and output registers
    // -------------------------------------------------------------------------
    logic [0:0]         state_q, state_d;
    logic [NUM_BTN-1:0] stop_q, stop_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic               error_q, error_d;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic               done_q, done_d;

`ifdef STOP_ANY_ORDER_EN
    // Any key that is not yet stopped (its Stop line is still 1) is accepted.
    logic [NUM_BTN-1:0] accept_mask;
    logic [REM_W-1:0]   accept_cnt;

    always_comb begin
        accept_mask = press_evt & stop_q;
        accept_cnt  = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            accept_cnt = accept_cnt + REM_W'(accept_mask[i]);
        end
    end
`else
    // One-hot mask of the slot that the stacking order expects next.
    logic [NUM_BTN-1:0] exp_mask;

    always_comb begin
        exp_mask = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            exp_mask[i] = (REM_W'(i) == (remaining_q - REM_W'(1)));
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        stop_d      = stop_q;
        press_d     = '0;
        error_d     = 1'b0;
        remaining_d = remaining_q;
        done_d      = done_q;

        if (Clear_i) begin
            // Clear overrides any coincident event, so no pulses this cycle.
            state_d     = ST_ARMED;
            stop_d      = '1;
            remaining_d = REM_FULL;
            done_d      = 1'b0;
        end else if (state_q == ST_ARMED) begin
`ifdef STOP_ANY_ORDER_EN
            stop_d      = stop_q & ~accept_mask;
            press_d     = accept_mask;
            remaining_d = remaining_q - accept_cnt;
            error_d     = |(press_evt & ~stop_q);
            if ((|accept_mask) && (remaining_q == accept_cnt)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
`else
            if (|(press_evt & exp_mask)) begin
                stop_d      = stop_q & ~exp_mask;
                press_d     = exp_mask;
                remaining_d = remaining_q - REM_W'(1);
                if (remaining_q == REM_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            // Any other event in the same cycle is still reported.
            error_d = |(press_evt & ~exp_mask);
`endif
        end else begin
            error_d = |press_evt;
        end
    end

    always_ff @(posedge Clock_i or negedge Resetn_i) begin
        if (!Resetn_i) begin
            state_q     <= ST_ARMED;
            stop_q      <= '1;
            press_q     <= '0;
            error_q     <= 1'b0;
            remaining_q <= REM_FULL;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            press_q     <= press_d;
            error_q     <= error_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    assign StopOut_o    = stop_q;
    assign PressPulse_o = press_q;
    assign ErrorPulse_o = error_q;
    assign Remaining_o  = remaining_q;
    assign Done_o       = done_q;

endmodule

// File: tb/tb_stop_key_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for stop_key_conditioner (NUM_BTN=4, DEBOUNCE_CYCLES=4).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point. The first rising edge after an input change is "edge 0".
// -----------------------------------------------------------------------------
module tb_stop_key_conditioner;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_in;
    logic       clear;
    logic [3:0] stop_out;
    logic [3:0] press_pulse;
    logic       error_pulse;
    logic [2:0] remaining;
    logic       done;

    int checks_total;
    int checks_passed;

    stop_key_conditioner #(
        .NUM_BTN        (4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .Clock_i     (clk),
        .Resetn_i    (rst_n),
        .KeyIn_i     (key_in),
        .Clear_i     (clear),
        .StopOut_o   (stop_out),
        .PressPulse_o(press_pulse),
        .ErrorPulse_o(error_pulse),
        .Remaining_o (remaining),
        .Done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds key idx low until just after the edge that accepts it (edge 5).
    task automatic press_hold(input int idx);
        key_in[idx] = 1'b0;
        repeat (6) tick();
    endtask

    task automatic release_keys();
        key_in = 4'b1111;
        repeat (7) tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 4'b1111;
        clear  = 1'b0;
        repeat (2) tick();
        checks_total++;
        if (stop_out !== 4'b1111 || remaining !== 3'd4 || done !== 1'b0 ||
            press_pulse !== 4'b0000 || error_pulse !== 1'b0)
            $display("FAIL reset_hold: stop=%b rem=%0d done=%b pp=%b err=%b want 1111/4/0/0000/0",
                     stop_out, remaining, done, press_pulse, error_pulse);
        else checks_passed++;
        rst_n = 1'b1;
        repeat (3) tick();
        checks_total++;
        if (stop_out !== 4'b1111 || remaining !== 3'd4 || done !== 1'b0 ||
            press_pulse !== 4'b0000 || error_pulse !== 1'b0)
            $display("FAIL reset_release: stop=%b rem=%0d done=%b pp=%b err=%b want 1111/4/0/0000/0",
                     stop_out, remaining, done, press_pulse, error_pulse);
        else checks_passed++;
        $display("test_reset done: stop=%b rem=%0d", stop_out, remaining);
    endtask

    task automatic test_latency();
        key_in[3] = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick();
            checks_total++;
            if (press_pulse !== 4'b0000)
                $display("FAIL latency_early edge%0d: pp=%b want 0000", e, press_pulse);
            else checks_passed++;
        end
        tick();  // edge 5
        checks_total++;
        if (press_pulse !== 4'b1000 || stop_out !== 4'b0111 || remaining !== 3'd3)
            $display("FAIL latency_accept: pp=%b stop=%b rem=%0d want 1000/0111/3",
                     press_pulse, stop_out, remaining);
        else checks_passed++;
        tick();
        checks_total++;
        if (press_pulse !== 4'b0000 || stop_out !== 4'b0111)
            $display("FAIL latency_width: pp=%b stop=%b want 0000/0111", press_pulse, stop_out);
        else checks_passed++;
        release_keys();
        $display("test_latency done: stop=%b rem=%0d", stop_out, remaining);
    endtask

    task automatic test_bounce();
        logic [5:0] pattern;
        pattern = 6'b100100;  // applied LSB first: low,low,high,low,low,high
        for (int i = 0; i < 6; i++) begin
            key_in[2] = pattern[i];
            tick();
            checks_total++;
            if (press_pulse !== 4'b0000 || error_pulse !== 1'b0)
                $display("FAIL bounce_quiet step%0d: pp=%b err=%b want 0000/0",
                         i, press_pulse, error_pulse);
            else checks_passed++;
        end
        key_in[2] = 1'b0;
        repeat (5) tick();
        checks_total++;
        if (press_pulse !== 4'b0000)
            $display("FAIL bounce_early: pp=%b want 0000", press_pulse);
        else checks_passed++;
        tick();
        checks_total++;
        if (press_pulse !== 4'b0100 || stop_out !== 4'b0011 || remaining !== 3'd2)
            $display("FAIL bounce_accept: pp=%b stop=%b rem=%0d want 0100/0011/2",
                     press_pulse, stop_out, remaining);
        else checks_passed++;
        release_keys();
        $display("test_bounce done: stop=%b rem=%0d", stop_out, remaining);
    endtask

    task automatic test_clear_coincident();
        do_clear();
        tick();
        checks_total++;
        if (stop_out !== 4'b1111 || remaining !== 3'd4 || done !== 1'b0)
            $display("FAIL clear_rearm: stop=%b rem=%0d done=%b want 1111/4/0",
                     stop_out, remaining, done);
        else checks_passed++;
        key_in[3] = 1'b0;
        repeat (5) tick();
        clear = 1'b1;
        tick();  // edge 5: key 3 would be accepted here
        clear = 1'b0;
        checks_total++;
        if (press_pulse !== 4'b0000 || error_pulse !== 1'b0 ||
            stop_out !== 4'b1111 || remaining !== 3'd4)
            $display("FAIL clear_beats_press: pp=%b err=%b stop=%b rem=%0d want 0000/0/1111/4",
                     press_pulse, error_pulse, stop_out, remaining);
        else checks_passed++;
        repeat (8) tick();  // key still held: no new event
        checks_total++;
        if (remaining !== 3'd4 || stop_out !== 4'b1111)
            $display("FAIL held_key: stop=%b rem=%0d want 1111/4", stop_out, remaining);
        else checks_passed++;
        release_keys();
        press_hold(3);
        checks_total++;
        if (press_pulse !== 4'b1000 || remaining !== 3'd3)
            $display("FAIL repress_after_clear: pp=%b rem=%0d want 1000/3", press_pulse, remaining);
        else checks_passed++;
        release_keys();
        $display("test_clear_coincident done: stop=%b rem=%0d", stop_out, remaining);
    endtask

`ifndef STOP_ANY_ORDER_EN
    task automatic test_order();
        logic [3:0] want_pp;
        do_clear();
        press_hold(1);
        checks_total++;
        if (error_pulse !== 1'b1 || press_pulse !== 4'b0000 ||
            stop_out !== 4'b1111 || remaining !== 3'd4)
            $display("FAIL order_reject: err=%b pp=%b stop=%b rem=%0d want 1/0000/1111/4",
                     error_pulse, press_pulse, stop_out, remaining);
        else checks_passed++;
        tick();
        checks_total++;
        if (error_pulse !== 1'b0)
            $display("FAIL order_err_width: err=%b want 0", error_pulse);
        else checks_passed++;
        release_keys();
        for (int k = 3; k >= 0; k--) begin
            press_hold(k);
            want_pp = 4'b0001 << k;
            checks_total++;
            if (press_pulse !== want_pp || remaining !== 3'(k) || error_pulse !== 1'b0)
                $display("FAIL order_seq key%0d: pp=%b rem=%0d err=%b want %b/%0d/0",
                         k, press_pulse, remaining, error_pulse, want_pp, k);
            else checks_passed++;
            release_keys();
        end
        checks_total++;
        if (done !== 1'b1 || stop_out !== 4'b0000)
            $display("FAIL order_done: done=%b stop=%b want 1/0000", done, stop_out);
        else checks_passed++;
        press_hold(2);
        checks_total++;
        if (error_pulse !== 1'b1 || press_pulse !== 4'b0000 || done !== 1'b1)
            $display("FAIL done_reject: err=%b pp=%b done=%b want 1/0000/1",
                     error_pulse, press_pulse, done);
        else checks_passed++;
        release_keys();
        $display("test_order done: done=%b rem=%0d", done, remaining);
    endtask

    task automatic test_simultaneous();
        // Remaining is 3, so key 2 is expected. Key 0 in the same cycle is an error.
        key_in = 4'b1010;
        repeat (6) tick();
        checks_total++;
        if (press_pulse !== 4'b0100 || error_pulse !== 1'b1 || remaining !== 3'd2)
            $display("FAIL simultaneous: pp=%b err=%b rem=%0d want 0100/1/2",
                     press_pulse, error_pulse, remaining);
        else checks_passed++;
        release_keys();
        $display("test_simultaneous done: stop=%b rem=%0d", stop_out, remaining);
    endtask
`else
    task automatic test_any_order();
        do_clear();
        press_hold(0);
        checks_total++;
        if (press_pulse !== 4'b0001 || error_pulse !== 1'b0 || remaining !== 3'd3)
            $display("FAIL any_key0: pp=%b err=%b rem=%0d want 0001/0/3",
                     press_pulse, error_pulse, remaining);
        else checks_passed++;
        release_keys();
        press_hold(3);
        checks_total++;
        if (press_pulse !== 4'b1000 || remaining !== 3'd2 || stop_out !== 4'b0110)
            $display("FAIL any_key3: pp=%b rem=%0d stop=%b want 1000/2/0110",
                     press_pulse, remaining, stop_out);
        else checks_passed++;
        release_keys();
        press_hold(0);
        checks_total++;
        if (error_pulse !== 1'b1 || press_pulse !== 4'b0000 || remaining !== 3'd2)
            $display("FAIL any_repress: err=%b pp=%b rem=%0d want 1/0000/2",
                     error_pulse, press_pulse, remaining);
        else checks_passed++;
        release_keys();
        key_in = 4'b1001;
        repeat (6) tick();
        checks_total++;
        if (press_pulse !== 4'b0110 || remaining !== 3'd0 || done !== 1'b1)
            $display("FAIL any_simul: pp=%b rem=%0d done=%b want 0110/0/1",
                     press_pulse, remaining, done);
        else checks_passed++;
        release_keys();
        do_clear();
        press_hold(3);
        release_keys();
        $display("test_any_order done: rem=%0d", remaining);
    endtask
`endif

    task automatic test_reset_mid();
        key_in[1] = 1'b0;
        repeat (3) tick();  // mid-debounce
        rst_n = 1'b0;
        #1;
        checks_total++;
        if (stop_out !== 4'b1111 || remaining !== 3'd4 || done !== 1'b0 ||
            press_pulse !== 4'b0000 || error_pulse !== 1'b0)
            $display("FAIL reset_async: stop=%b rem=%0d done=%b pp=%b err=%b want 1111/4/0/0000/0",
                     stop_out, remaining, done, press_pulse, error_pulse);
        else checks_passed++;
        key_in = 4'b1111;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks_total++;
            if (press_pulse !== 4'b0000 || remaining !== 3'd4)
                $display("FAIL reset_discard cyc%0d: pp=%b rem=%0d want 0000/4",
                         i, press_pulse, remaining);
            else checks_passed++;
        end
        $display("test_reset_mid done: rem=%0d", remaining);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_latency();
        test_bounce();
        test_clear_coincident();
`ifndef STOP_ANY_ORDER_EN
        test_simultaneous();
        test_order();
`else
        test_any_order();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
